// File: rtl/capture_ctrl_4kx32.sv
// Triggered capture controller for a 2^AW x DW circular sample buffer.
// Writes every sample while armed and after the trigger, then maps chronological read indices to buffer addresses.
module capture_ctrl_4kx32 #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arm,
    input  logic          abort,
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] trig0,
    input  logic [DW-1:0] trig_value,
    input  logic [DW-1:0] trig_mask,
    input  logic [AW-1:0] post_count,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    input  logic [AW-1:0] rd_idx,
    output logic [AW-1:0] ram_raddr,
    output logic          busy,
    output logic          triggered,
    output logic          done,
    output logic [AW-1:0] trig_addr,
    output logic [AW:0]   sample_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_r;
    logic [AW-1:0] ptr_r;
    logic [AW-1:0] post_r;
    logic          ram_we_r;
    logic [AW-1:0] ram_waddr_r;
    logic [DW-1:0] ram_wdata_r;
    logic [AW-1:0] ram_raddr_r;
    logic          busy_r;
    logic          triggered_r;
    logic          done_r;
    logic [AW-1:0] trig_addr_r;
    logic [AW:0]   sample_count_r;

    logic          trig_hit_s;
    logic [AW-1:0] start_s;

    assign trig_hit_s = ((trig0 & trig_mask) == (trig_value & trig_mask));

    // Oldest valid sample: address 0 until the buffer has wrapped, then the next write slot.
    always_comb begin
        start_s = {AW{1'b0}};
        if (sample_count_r[AW]) begin
            start_s = ptr_r;
        end else begin
            start_s = {AW{1'b0}};
        end
    end

    // Capture FSM with its registered write port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            ptr_r          <= {AW{1'b0}};
            post_r         <= {AW{1'b0}};
            ram_we_r       <= 1'b0;
            ram_waddr_r    <= {AW{1'b0}};
            ram_wdata_r    <= {DW{1'b0}};
            busy_r         <= 1'b0;
            triggered_r    <= 1'b0;
            done_r         <= 1'b0;
            trig_addr_r    <= {AW{1'b0}};
            sample_count_r <= {(AW+1){1'b0}};
        end else if (abort) begin
            state_r     <= IDLE;
            ram_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            triggered_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    ram_we_r <= 1'b0;
                    if (arm) begin
                        post_r         <= post_count;
                        ptr_r          <= {AW{1'b0}};
                        sample_count_r <= {(AW+1){1'b0}};
                        triggered_r    <= 1'b0;
                        done_r         <= 1'b0;
                        busy_r         <= 1'b1;
                        state_r        <= ARMED;
                    end else begin
                        // done rises one cycle after entering DONE, i.e. after the last write is visible.
                        done_r <= (state_r == DONE);
                        busy_r <= 1'b0;
                    end
                end
                ARMED, POST: begin
                    ram_we_r    <= 1'b1;
                    ram_wdata_r <= data;
                    ram_waddr_r <= ptr_r;
                    ptr_r       <= ptr_r + AW'(1);
                    if (!sample_count_r[AW]) begin
                        sample_count_r <= sample_count_r + (AW+1)'(1);
                    end
                    if (state_r == ARMED) begin
                        if (trig_hit_s) begin
                            trig_addr_r <= ptr_r;
                            triggered_r <= 1'b1;
                            if (post_r == {AW{1'b0}}) begin
                                state_r <= DONE;
                                busy_r  <= 1'b0;
                            end else begin
                                state_r <= POST;
                            end
                        end
                    end else begin
                        post_r <= post_r - AW'(1);
                        if (post_r <= AW'(1)) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    ram_we_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    // Chronological readout address, one cycle behind rd_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_raddr_r <= {AW{1'b0}};
        end else begin
            ram_raddr_r <= start_s + rd_idx;
        end
    end

    assign ram_we       = ram_we_r;
    assign ram_waddr    = ram_waddr_r;
    assign ram_wdata    = ram_wdata_r;
    assign ram_raddr    = ram_raddr_r;
    assign busy         = busy_r;
    assign triggered    = triggered_r;
    assign done         = done_r;
    assign trig_addr    = trig_addr_r;
    assign sample_count = sample_count_r;

endmodule

// File: tb/tb_capture_ctrl_4kx32.sv
// Directed bench for capture_ctrl_4kx32: trigger placement, wrap, post_count=0, abort and reset cases.
module tb_capture_ctrl_4kx32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] data = 32'd0;
    logic [31:0] trig0 = 32'd0;
    logic [31:0] trig_value = 32'd0;
    logic [31:0] trig_mask = 32'd0;
    logic [11:0] post_count = 12'd0;
    logic        ram_we;
    logic [11:0] ram_waddr;
    logic [31:0] ram_wdata;
    logic [11:0] rd_idx = 12'd0;
    logic [11:0] ram_raddr;
    logic        busy;
    logic        triggered;
    logic        done;
    logic [11:0] trig_addr;
    logic [12:0] sample_count;

    int checks = 0;
    int errors = 0;
    int we_total = 0;
    int wrap_total = 0;
    int we_base = 0;
    int wrap_base = 0;
    logic [11:0] prev_addr = 12'd0;
    logic        prev_we = 1'b0;

    capture_ctrl_4kx32 #(.AW(12), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .data(data),
        .trig0(trig0), .trig_value(trig_value), .trig_mask(trig_mask),
        .post_count(post_count), .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .rd_idx(rd_idx), .ram_raddr(ram_raddr),
        .busy(busy), .triggered(triggered), .done(done),
        .trig_addr(trig_addr), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    // Write-port monitor: counts pulses and 4095->0 address wraps, sampled on the falling edge.
    always @(negedge clk) begin
        if (ram_we) begin
            we_total = we_total + 1;
            if (prev_we && prev_addr == 12'd4095 && ram_waddr == 12'd0) begin
                wrap_total = wrap_total + 1;
            end
            prev_addr = ram_waddr;
        end
        prev_we = ram_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        #2;
        we_base   = we_total;
        wrap_base = wrap_total;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_we", {63'd0, ram_we}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_cnt", {51'd0, sample_count}, 64'd0);
        check("rst_raddr", {52'd0, ram_raddr}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", {63'd0, busy}, 64'd0);

        // Scenario A: mask=0, post_count=3
        mark();
        trig_mask = 32'd0; post_count = 12'd3; arm = 1'b1;
        tick();
        arm = 1'b0; data = 32'hA000_0000;
        check("a_busy", {63'd0, busy}, 64'd1);
        check("a_we_arm", {63'd0, ram_we}, 64'd0);
        tick();
        check("a_we0", {63'd0, ram_we}, 64'd1);
        check("a_addr0", {52'd0, ram_waddr}, 64'd0);
        check("a_wdata0", {32'd0, ram_wdata}, 64'hA000_0000);
        check("a_trig", {63'd0, triggered}, 64'd1);
        check("a_taddr", {52'd0, trig_addr}, 64'd0);
        tick(); tick(); tick();
        check("a_addr3", {52'd0, ram_waddr}, 64'd3);
        check("a_done_early", {63'd0, done}, 64'd0);
        rd_idx = 12'd2;
        tick();
        check("a_done", {63'd0, done}, 64'd1);
        check("a_we_off", {63'd0, ram_we}, 64'd0);
        check("a_cnt", {51'd0, sample_count}, 64'd4);
        tick();
        check("a_raddr", {52'd0, ram_raddr}, 64'd2);
        check("a_nwe", 64'(we_total - we_base), 64'd4);

        // Scenario B: trigger on 10th ARMED cycle, post_count=5, arm ignored in POST
        mark();
        trig_mask = 32'hFFFF_FFFF; trig_value = 32'h0000_1234; trig0 = 32'd0;
        post_count = 12'd5; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            trig0 = (i == 9) ? 32'h0000_1234 : 32'd0;
            tick();
        end
        trig0 = 32'd0;
        check("b_trig", {63'd0, triggered}, 64'd1);
        check("b_taddr", {52'd0, trig_addr}, 64'd9);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("b_arm_ign", {52'd0, ram_waddr}, 64'd10);
        tick(); tick(); tick(); tick();
        check("b_addr14", {52'd0, ram_waddr}, 64'd14);
        tick();
        check("b_done", {63'd0, done}, 64'd1);
        check("b_cnt", {51'd0, sample_count}, 64'd15);
        check("b_nwe", 64'(we_total - we_base), 64'd15);

        // Scenario C: trigger after 5000 cycles, post_count=100 -> wrapped buffer
        mark();
        trig_value = 32'h0000_DEAD; post_count = 12'd100; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            tick();
        end
        check("c_notrig", {63'd0, triggered}, 64'd0);
        trig0 = 32'h0000_DEAD;
        tick();
        trig0 = 32'd0;
        check("c_taddr", {52'd0, trig_addr}, 64'd904);
        for (int i = 0; i < 100; i++) begin
            tick();
        end
        rd_idx = 12'd0;
        tick();
        check("c_done", {63'd0, done}, 64'd1);
        check("c_cnt", {51'd0, sample_count}, 64'd4096);
        tick();
        check("c_raddr0", {52'd0, ram_raddr}, 64'd1005);
        rd_idx = 12'd4095;
        tick();
        check("c_raddr_last", {52'd0, ram_raddr}, 64'd1004);
        check("c_nwe", 64'(we_total - we_base), 64'd5101);
        check("c_wrap", 64'(wrap_total - wrap_base), 64'd1);

        // Scenario D: post_count=0 with immediate trigger
        mark();
        trig_mask = 32'd0; post_count = 12'd0; arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        check("d_we", {63'd0, ram_we}, 64'd1);
        check("d_done_early", {63'd0, done}, 64'd0);
        tick();
        check("d_done", {63'd0, done}, 64'd1);
        check("d_we_off", {63'd0, ram_we}, 64'd0);
        tick(); tick();
        check("d_nwe", 64'(we_total - we_base), 64'd1);

        // Scenario E: abort coincident with trigger
        mark();
        trig_mask = 32'hFFFF_FFFF; trig_value = 32'h0000_0055; trig0 = 32'd0;
        post_count = 12'd4; arm = 1'b1;
        tick();
        arm = 1'b0;
        tick(); tick();
        trig0 = 32'h0000_0055; abort = 1'b1;
        tick();
        abort = 1'b0; trig0 = 32'd0;
        check("e_we", {63'd0, ram_we}, 64'd0);
        check("e_trig", {63'd0, triggered}, 64'd0);
        check("e_busy", {63'd0, busy}, 64'd0);
        trig0 = 32'h0000_0055;
        tick(); tick(); tick();
        trig0 = 32'd0;
        check("e_idle_trig", {63'd0, triggered}, 64'd0);
        check("e_nwe", 64'(we_total - we_base), 64'd2);

        // Scenario F: reset asserted in POST
        trig_mask = 32'd0; post_count = 12'd10; arm = 1'b1;
        tick();
        arm = 1'b0;
        tick(); tick();
        check("f_busy_pre", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("f_we", {63'd0, ram_we}, 64'd0);
        check("f_busy", {63'd0, busy}, 64'd0);
        check("f_trig", {63'd0, triggered}, 64'd0);
        check("f_waddr", {52'd0, ram_waddr}, 64'd0);
        check("f_taddr", {52'd0, trig_addr}, 64'd0);
        check("f_cnt", {51'd0, sample_count}, 64'd0);
        tick();
        rst_n = 1'b1;
        mark();
        tick(); tick(); tick();
        check("f_nwe", 64'(we_total - we_base), 64'd0);
        check("f_idle", {63'd0, busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
